// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS-style pipeline slice.
package mips_pipe_pkg;

    localparam int ALU_OP_W   = 4;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // Control bundle carried from ID into EX.
    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_NOP = '{
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        alu_op:     4'd0
    };

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard check between the load sitting in EX and
// the instruction currently decoded in ID.
module load_use_detector
    import mips_pipe_pkg::*;
(
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    output logic                  lu
);

    // A load writing a non-zero register that ID reads as a source forces a stall.
    always_comb begin
        lu = 1'b0;
        if (id_valid && ex_valid && ex_mem_read && (ex_dst != REG_ZERO)) begin
            lu = (ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt));
        end else begin
            lu = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush
// squash, downstream hold and saturating bubble/flush event counters.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [3:0]        id_alu_op,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dst,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic [3:0]        ex_alu_op,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic                  ex_valid_r;
    ex_ctrl_t              ctrl_r;
    logic [REG_ADDR_W-1:0] ex_rs_r, ex_rt_r, ex_dst_r;
    logic [DATA_W-1:0]     ex_rs_data_r, ex_rt_data_r, ex_imm_r;
    logic [CNT_W-1:0]      bubble_cnt_r, flush_cnt_r;

    logic                  lu_s;
    logic [REG_ADDR_W-1:0] dst_s;
    ex_ctrl_t              ctrl_in_s;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    load_use_detector u_lu (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_valid    (ex_valid_r),
        .ex_mem_read (ctrl_r.mem_read),
        .ex_dst      (ex_dst_r),
        .lu          (lu_s)
    );

    // Resolve destination and gate incoming control with id_valid so an empty
    // ID slot can never produce a write in EX.
    always_comb begin
        dst_s     = id_reg_dst ? id_rd : id_rt;
        ctrl_in_s = CTRL_NOP;
        if (id_valid) begin
            ctrl_in_s.reg_write  = id_reg_write;
            ctrl_in_s.mem_read   = id_mem_read;
            ctrl_in_s.mem_write  = id_mem_write;
            ctrl_in_s.mem_to_reg = id_mem_to_reg;
            ctrl_in_s.alu_src    = id_alu_src;
            ctrl_in_s.alu_op     = id_alu_op;
        end else begin
            ctrl_in_s = CTRL_NOP;
        end
    end

    // Stall request: flush overrides; forced low while reset is asserted.
    always_comb begin
        id_stall = rst_n & ~flush_i & (hold_i | lu_s);
    end

    // Pipeline register update with priority flush > hold > bubble > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r   <= 1'b0;
            ctrl_r       <= CTRL_NOP;
            ex_rs_r      <= REG_ZERO;
            ex_rt_r      <= REG_ZERO;
            ex_dst_r     <= REG_ZERO;
            ex_rs_data_r <= {DATA_W{1'b0}};
            ex_rt_data_r <= {DATA_W{1'b0}};
            ex_imm_r     <= {DATA_W{1'b0}};
        end else if (flush_i) begin
            ex_valid_r   <= 1'b0;
            ctrl_r       <= CTRL_NOP;
        end else if (hold_i) begin
            ex_valid_r   <= ex_valid_r;
            ctrl_r       <= ctrl_r;
        end else if (lu_s) begin
            ex_valid_r   <= 1'b0;
            ctrl_r       <= CTRL_NOP;
            ex_rs_r      <= REG_ZERO;
            ex_rt_r      <= REG_ZERO;
            ex_dst_r     <= REG_ZERO;
            ex_rs_data_r <= {DATA_W{1'b0}};
            ex_rt_data_r <= {DATA_W{1'b0}};
            ex_imm_r     <= {DATA_W{1'b0}};
        end else begin
            ex_valid_r   <= id_valid;
            ctrl_r       <= ctrl_in_s;
            ex_rs_r      <= id_rs;
            ex_rt_r      <= id_rt;
            ex_dst_r     <= dst_s;
            ex_rs_data_r <= id_rs_data;
            ex_rt_data_r <= id_rt_data;
            ex_imm_r     <= id_imm;
        end
    end

    // Event counters: a flush cycle never also counts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            flush_cnt_r  <= sat_inc(flush_cnt_r);
        end else if (!hold_i && lu_s) begin
            bubble_cnt_r <= sat_inc(bubble_cnt_r);
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
            flush_cnt_r  <= flush_cnt_r;
        end
    end

    assign ex_valid      = ex_valid_r;
    assign ex_rs         = ex_rs_r;
    assign ex_rt         = ex_rt_r;
    assign ex_dst        = ex_dst_r;
    assign ex_rs_data    = ex_rs_data_r;
    assign ex_rt_data    = ex_rt_data_r;
    assign ex_imm        = ex_imm_r;
    assign ex_reg_write  = ctrl_r.reg_write;
    assign ex_mem_read   = ctrl_r.mem_read;
    assign ex_mem_write  = ctrl_r.mem_write;
    assign ex_mem_to_reg = ctrl_r.mem_to_reg;
    assign ex_alu_src    = ctrl_r.alu_src;
    assign ex_alu_op     = ctrl_r.alu_op;
    assign bubble_cnt    = bubble_cnt_r;
    assign flush_cnt     = flush_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, load-use bubble, $0 and
// Rt-not-used cases, flush priority, hold, chained loads, mid-stall reset
// and counter saturation (counters narrowed to 8 bits to keep runtime short).
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              id_uses_rt;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic              id_alu_src, id_reg_dst;
    logic [3:0]        id_alu_op;
    logic              flush_i, hold_i;
    logic              id_stall, ex_valid;
    logic [4:0]        ex_rs, ex_rt, ex_dst;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [3:0]        ex_alu_op;
    logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

    int tests  = 0;
    int failed = 0;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
        .flush_i(flush_i), .hold_i(hold_i), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load word: rt <- mem[rs + imm]
    task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = 5'd0; id_uses_rt = 1'b0;
        id_rs_data = 32'h1000; id_rt_data = 32'd0; id_imm = imm;
        id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b0;
        id_mem_to_reg = 1'b1; id_alu_src = 1'b1; id_reg_dst = 1'b0; id_alu_op = 4'd0;
    endtask

    // R-type: rd <- rs op rt
    task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [3:0] op, input logic [31:0] rsd, input logic [31:0] rtd);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = 1'b1;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = 32'd0;
        id_reg_write = 1'b1; id_mem_read = 1'b0; id_mem_write = 1'b0;
        id_mem_to_reg = 1'b0; id_alu_src = 1'b0; id_reg_dst = 1'b1; id_alu_op = op;
    endtask

    // addi: rt <- rs + imm (rt is a destination, not a source)
    task automatic set_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = 5'd0; id_uses_rt = 1'b0;
        id_rs_data = 32'd7; id_rt_data = 32'd0; id_imm = imm;
        id_reg_write = 1'b1; id_mem_read = 1'b0; id_mem_write = 1'b0;
        id_mem_to_reg = 1'b0; id_alu_src = 1'b1; id_reg_dst = 1'b0; id_alu_op = 4'd1;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0; flush_i = 1'b0; hold_i = 1'b1;
        id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_uses_rt = 1'b0;
        id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
        id_mem_to_reg = 1'b0; id_alu_src = 1'b0; id_reg_dst = 1'b0; id_alu_op = 4'd0;
        #2;
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_stall", 64'(id_stall), 64'd0);
        check("rst_bcnt", 64'(bubble_cnt), 64'd0);
        check("rst_fcnt", 64'(flush_cnt), 64'd0);
        hold_i = 1'b0;
        rst_n = 1'b1;
        step();

        // lw $5, 16($2) enters EX
        set_lw(5'd2, 5'd5, 32'd16);
        step();
        check("lw_valid", 64'(ex_valid), 64'd1);
        check("lw_dst", 64'(ex_dst), 64'd5);
        check("lw_mrd", 64'(ex_mem_read), 64'd1);
        check("lw_imm", 64'(ex_imm), 64'd16);
        check("lw_rs", 64'(ex_rs), 64'd2);

        // add $7,$5,$6 in ID -> one bubble
        set_rtype(5'd5, 5'd6, 5'd7, 4'd2, 32'd11, 32'd22);
        #1;
        check("lu_stall", 64'(id_stall), 64'd1);
        step();
        check("bub_valid", 64'(ex_valid), 64'd0);
        check("bub_regw", 64'(ex_reg_write), 64'd0);
        check("bub_mrd", 64'(ex_mem_read), 64'd0);
        check("bub_dst", 64'(ex_dst), 64'd0);
        check("bub_cnt1", 64'(bubble_cnt), 64'd1);
        check("bub_nostall", 64'(id_stall), 64'd0);
        step();
        check("add_valid", 64'(ex_valid), 64'd1);
        check("add_dst", 64'(ex_dst), 64'd7);
        check("add_op", 64'(ex_alu_op), 64'd2);
        check("add_rsd", 64'(ex_rs_data), 64'd11);
        check("add_rtd", 64'(ex_rt_data), 64'd22);
        check("add_bcnt", 64'(bubble_cnt), 64'd1);

        // lw $0 in EX, ID reads $0 -> no stall
        set_lw(5'd1, 5'd0, 32'd4);
        step();
        set_rtype(5'd0, 5'd0, 5'd9, 4'd2, 32'd0, 32'd0);
        #1;
        check("r0_nostall", 64'(id_stall), 64'd0);
        step();
        // lw $5 in EX, ID addi $5,$3 (rt not a source) -> no stall
        set_lw(5'd1, 5'd5, 32'd8);
        step();
        set_addi(5'd3, 5'd5, 32'd1);
        #1;
        check("addi_nostall", 64'(id_stall), 64'd0);

        // Flush coincides with a load-use hazard
        set_rtype(5'd5, 5'd6, 5'd7, 4'd2, 32'd1, 32'd2);
        #1;
        check("pre_fl_stall", 64'(id_stall), 64'd1);
        flush_i = 1'b1;
        #1;
        check("fl_stall", 64'(id_stall), 64'd0);
        step();
        flush_i = 1'b0;
        check("fl_valid", 64'(ex_valid), 64'd0);
        check("fl_regw", 64'(ex_reg_write), 64'd0);
        check("fl_fcnt", 64'(flush_cnt), 64'd1);
        check("fl_bcnt", 64'(bubble_cnt), 64'd1);

        // Hold for 3 cycles with changing ID inputs
        set_rtype(5'd1, 5'd2, 5'd3, 4'd3, 32'h111, 32'h222);
        step();
        check("hpre_dst", 64'(ex_dst), 64'd3);
        check("hpre_regw", 64'(ex_reg_write), 64'd1);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rtype(5'(i + 4), 5'(i + 8), 5'(i + 12), 4'(i + 5), 32'(i), 32'(i));
            #1;
            check("hold_stall", 64'(id_stall), 64'd1);
            step();
            check("hold_dst", 64'(ex_dst), 64'd3);
            check("hold_rsd", 64'(ex_rs_data), 64'h111);
            check("hold_op", 64'(ex_alu_op), 64'd3);
            check("hold_valid", 64'(ex_valid), 64'd1);
            check("hold_bcnt", 64'(bubble_cnt), 64'd1);
            check("hold_fcnt", 64'(flush_cnt), 64'd1);
        end
        hold_i = 1'b0;

        // Back-to-back load-use chain: one bubble per pair
        set_lw(5'd1, 5'd5, 32'd0);
        step();
        set_lw(5'd5, 5'd6, 32'd0);
        #1;
        check("ch1_stall", 64'(id_stall), 64'd1);
        step();
        check("ch1_bcnt", 64'(bubble_cnt), 64'd2);
        check("ch1_valid", 64'(ex_valid), 64'd0);
        step();
        check("ch1_dst", 64'(ex_dst), 64'd6);
        set_rtype(5'd6, 5'd7, 5'd8, 4'd2, 32'd0, 32'd0);
        #1;
        check("ch2_stall", 64'(id_stall), 64'd1);
        step();
        check("ch2_bcnt", 64'(bubble_cnt), 64'd3);
        step();
        check("ch2_dst", 64'(ex_dst), 64'd8);
        check("ch2_valid", 64'(ex_valid), 64'd1);

        // Reset while a load-use stall is pending (hazard via rt)
        set_lw(5'd1, 5'd5, 32'd0);
        step();
        set_rtype(5'd2, 5'd5, 5'd7, 4'd2, 32'd3, 32'd4);
        #1;
        check("mrs_stall", 64'(id_stall), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mrs_valid", 64'(ex_valid), 64'd0);
        check("mrs_mrd", 64'(ex_mem_read), 64'd0);
        check("mrs_dst", 64'(ex_dst), 64'd0);
        check("mrs_bcnt", 64'(bubble_cnt), 64'd0);
        check("mrs_fcnt", 64'(flush_cnt), 64'd0);
        check("mrs_stall0", 64'(id_stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_valid", 64'(ex_valid), 64'd1);
        check("post_dst", 64'(ex_dst), 64'd7);
        check("post_bcnt", 64'(bubble_cnt), 64'd0);

        // Bubble counter saturation: lw $5,($5) repeatedly -> 258 bubbles
        set_lw(5'd5, 5'd5, 32'd0);
        step();
        for (int i = 0; i < 2 * ((1 << CNT_W) + 2); i++) begin
            step();
        end
        check("bsat", 64'(bubble_cnt), 64'hFF);

        // Flush counter saturation: 258 flushes
        flush_i = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
            step();
        end
        flush_i = 1'b0;
        check("fsat", 64'(flush_cnt), 64'hFF);
        check("fsat_bcnt", 64'(bubble_cnt), 64'hFF);
        check("fsat_valid", 64'(ex_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
